core_sram_responder: RTL
========================

// Module: core_sram_responder
// PURPOSE
//  Memory-side responder for the core's inst_sram and data_sram initiator ports.
//  - Serves 64-bit dual-word instruction fetches and 32-bit byte-masked data accesses.
//  - Both ports have fixed 1-cycle read latency. The core has no wait handshake.
//  - Used as the SoC-lite memory for simulation and FPGA bring-up.
//  - Translates kseg0/kseg1 addresses and flags out-of-range accesses.
// PARAMETERS
//  ADDR_W    16            word-address bits; memory = 2^ADDR_W 32-bit words
//  OOR_DATA  32'h0000_0000 read value returned for out-of-range words
// PORTS
//  clk                in   1   single clock; all state updates on its rising edge
//  rst                in   1   reset, asynchronous, active-low
//  inst_sram_en       in   1   fetch request
//  inst_sram_wen      in   4   must be 0; nonzero is an error and is never written
//  inst_sram_addr     in   32  virtual byte address of the fetch, word aligned
//  inst_sram_wdata    in   32  ignored
//  inst_sram_rdata    out  64  [31:0]=word at addr, [63:32]=word at addr+4
//  data_sram_en       in   1   data request
//  data_sram_wen      in   4   byte-lane write enables; 0 means read
//  data_sram_addr     in   32  virtual byte address, word aligned
//  data_sram_wdata    in   32  write data, lane-aligned
//  data_sram_rdata    out  32  read data
//  err_o              out  2   sticky; [0]=out-of-range access, [1]=inst-port write attempt
//  conflict_cnt_o     out  16  count of same-word inst/data collisions, saturating
// BEHAVIOUR
//  - Translation: if addr[31:30]==2'b10 (kseg0/kseg1), paddr = {3'b0, addr[28:0]}; else paddr = addr.
//  - Word index w = paddr[ADDR_W+1:2]. The access is out-of-range (OOR) if paddr[31:ADDR_W+2] != 0.
//  - Fetch: sampled when inst_sram_en=1. Reads word w and word (w+1) mod 2^ADDR_W.
//  - Fetch result appears on inst_sram_rdata on the next edge and holds while en=0.
//  - OOR fetch: both halves = OOR_DATA and err_o[0] is set. Wrap-around at the top word is not OOR.
//  - Data read: sampled when en=1 and wen=0. Result appears on data_sram_rdata on the next edge.
//  - data_sram_rdata holds its value across writes and idle cycles.
//  - Data write: when en=1 and wen!=0, only lanes with wen[i]=1 are updated, at that edge.
//  - OOR write: dropped, and err_o[0] is set.
//  - Collision: data write and fetch in the same cycle touching the same word.
//    The fetch returns the write-first value, merged byte-wise per wen.
//    conflict_cnt_o increments once per such cycle (read or write data op), saturating at 16'hFFFF.
//  - inst_sram_wen != 0 with en=1: no write occurs, the fetch still proceeds, and err_o[1] is set.
//  - err_o is sticky and clears only on reset.
//  - Reset (async assert):
//    - inst_sram_rdata=0, data_sram_rdata=0, err_o=0, conflict_cnt_o=0.
//    - Any in-flight read is discarded; outputs stay 0 until the next sampled request.
//    - Memory contents are not reset.
//    - Requests are ignored while rst=0.
// STRUCTURE
//  - Two 32-bit banks: bank0 holds even words, bank1 holds odd words, row = w>>1.
//  - Fetch with w even: both banks read row r. Fetch with w odd: bank1 reads row r, bank0 reads row r+1 mod rows.
//  - Halves are swapped into order using the registered copy of w[0].
//  - Package sram_resp_pkg:
//    - KSEG01_TAG=2'b10 and a va_to_pa function.
//    - Bank-select/row helpers and a byte-merge function (wdata, old, wen).
//  - Sub-module sram_bank_2r1w (instantiated twice):
//    - 2^(ADDR_W-1) x 32 storage.
//    - Two synchronous read ports and one byte-masked write port, write-first on address match.
//    - No reset on storage.
// TESTING
//  1. Write 32'h1122_3344 to 0x8000_0010 (wen=4'hF), then fetch 0xA000_0010
//     -> next cycle rdata[31:0]=32'h1122_3344 (kseg aliasing).
//  2. Words 5 and 6 hold A and B; fetch 0x0000_0014 -> rdata={B,A}.
//     Fetch the top word 0x3FFFC (ADDR_W=16) -> upper half = word 0, err_o=0.
//  3. Word 0 = 32'hAABBCCDD; write wen=4'b0010, wdata=32'h0000_EE00, and fetch word 0 in the same cycle
//     -> fetch returns 32'hAABBEEDD and conflict_cnt_o increments to 1.
//  4. Data read 0x0004_0000 (OOR for ADDR_W=16) -> data_sram_rdata=OOR_DATA and err_o=2'b01.
//     A write to the same address leaves memory unchanged.
//  5. inst_sram_wen=4'hF on a fetch -> no memory change, err_o[1]=1, fetch data still correct.
//  6. Assert rst low while a fetch is pending -> both rdata=0 and counter=0.
//     After release with no request, rdata stays 0; memory is preserved on the next read.

Source files
------------

// File: rtl/sram_resp_pkg.sv
// Shared types and helpers for the core SRAM responder.
// Address translation, bank/row selection and byte merging.
package sram_resp_pkg;

   localparam logic [1:0] KSEG01_TAG = 2'b10;

   // kseg0/kseg1 alias onto the low 512 MiB of physical space
   function automatic logic [31:0] va_to_pa(input logic [31:0] va);
      if (va[31:30] == KSEG01_TAG)
         return {3'b000, va[28:0]};
      else
         return va;
   endfunction

   // Odd words live in bank1, even words in bank0
   function automatic logic pa_bank(input logic [31:0] pa);
      return (pa & 32'h0000_0004) != 32'h0;
   endfunction

   // Row inside a bank is the word index halved
   function automatic logic [31:0] pa_row(input logic [31:0] pa);
      return pa >> 3;
   endfunction

   // Replace only the lanes enabled in wen
   function automatic logic [31:0] merge_bytes(
      input logic [31:0] wdata,
      input logic [31:0] old,
      input logic [3:0]  wen
   );
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++)
         if (wen[i])
            r[8*i +: 8] = wdata[8*i +: 8];
      return r;
   endfunction

endpackage

// File: rtl/core_sram_responder_bank.sv
// One 32-bit bank: two synchronous read ports, one byte-masked write port.
// Reads see same-edge writes (write-first); storage is not reset.
module sram_bank_2r1w
   import sram_resp_pkg::*;
#(
   parameter int ROW_W = 15
) (
   input  logic             clk,
   input  logic             ra_en,
   input  logic [ROW_W-1:0] ra_addr,
   output logic [31:0]      ra_data,
   input  logic             rb_en,
   input  logic [ROW_W-1:0] rb_addr,
   output logic [31:0]      rb_data,
   input  logic [3:0]       we,
   input  logic [ROW_W-1:0] waddr,
   input  logic [31:0]      wdata
);

   localparam int ROWS = 1 << ROW_W;

   logic [31:0] mem [ROWS];
   logic [31:0] ra_data_d, ra_data_q;
   logic [31:0] rb_data_d, rb_data_q;

   // Byte-masked write into storage
   always_ff @(posedge clk) begin
      if (|we)
         mem[waddr] <= merge_bytes(wdata, mem[waddr], we);
   end

   // Read ports: forward the merged write on row match, else hold when idle
   always_comb begin
      ra_data_d = ra_data_q;
      rb_data_d = rb_data_q;
      if (ra_en) begin
         if (|we && waddr == ra_addr)
            ra_data_d = merge_bytes(wdata, mem[ra_addr], we);
         else
            ra_data_d = mem[ra_addr];
      end
      if (rb_en) begin
         if (|we && waddr == rb_addr)
            rb_data_d = merge_bytes(wdata, mem[rb_addr], we);
         else
            rb_data_d = mem[rb_addr];
      end
   end

   // Read data registers
   always_ff @(posedge clk) begin
      ra_data_q <= ra_data_d;
      rb_data_q <= rb_data_d;
   end

   assign ra_data = ra_data_q;
   assign rb_data = rb_data_q;

endmodule

// File: rtl/core_sram_responder.sv
// Memory-side responder for the core inst/data SRAM ports.
// Dual-word fetches over two interleaved banks, byte-masked data port.
module core_sram_responder
   import sram_resp_pkg::*;
#(
   parameter int          ADDR_W   = 16,
   parameter logic [31:0] OOR_DATA = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_sram_en,
   input  logic [3:0]  inst_sram_wen,
   input  logic [31:0] inst_sram_addr,
   input  logic [31:0] inst_sram_wdata,
   output logic [63:0] inst_sram_rdata,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_wen,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic [1:0]  err_o,
   output logic [15:0] conflict_cnt_o
);

   localparam int ROW_W = ADDR_W - 1;
   localparam logic [ROW_W-1:0]  R_ONE = 1;
   localparam logic [ADDR_W-1:0] W_ONE = 1;

   logic [31:0]       i_pa, d_pa;
   logic [ADDR_W-1:0] i_w, d_w;
   logic [ROW_W-1:0]  i_row, d_row;
   logic              i_odd, d_odd, i_oor, d_oor;
   logic              i_req, d_req, d_wr, d_rd;
   logic              coll;
   logic [3:0]        we0, we1;
   logic [31:0]       b0a, b1a, b0b, b1b;
   logic              unused_bits;

   logic        i_vld_d, i_vld_q, i_odd_d, i_odd_q, i_oor_d, i_oor_q;
   logic        d_vld_d, d_vld_q, d_odd_d, d_odd_q, d_oor_d, d_oor_q;
   logic [1:0]  err_d, err_q;
   logic [15:0] cnt_d, cnt_q;

   assign i_pa  = va_to_pa(inst_sram_addr);
   assign d_pa  = va_to_pa(data_sram_addr);
   assign i_w   = i_pa[ADDR_W+1:2];
   assign d_w   = d_pa[ADDR_W+1:2];
   assign i_row = ROW_W'(pa_row(i_pa));
   assign d_row = ROW_W'(pa_row(d_pa));
   assign i_odd = pa_bank(i_pa);
   assign d_odd = pa_bank(d_pa);
   assign i_oor = i_pa[31:ADDR_W+2] != '0;
   assign d_oor = d_pa[31:ADDR_W+2] != '0;

   assign i_req = inst_sram_en & rst;
   assign d_req = data_sram_en & rst;
   assign d_wr  = d_req & (|data_sram_wen);
   assign d_rd  = d_req & ~(|data_sram_wen);

   assign we0 = (d_wr & ~d_oor & ~d_odd) ? data_sram_wen : 4'h0;
   assign we1 = (d_wr & ~d_oor &  d_odd) ? data_sram_wen : 4'h0;

   // Fetch reads two words; a data op on either of them is a collision
   assign coll = i_req & d_req & ~i_oor & ~d_oor
               & ((d_w == i_w) || (d_w == i_w + W_ONE));

   assign unused_bits = ^{inst_sram_wdata, i_pa[1:0], d_pa[1:0]};

   sram_bank_2r1w #(.ROW_W(ROW_W)) u_bank0 (
      .clk     (clk),
      .ra_en   (i_req),
      .ra_addr (i_odd ? i_row + R_ONE : i_row),
      .ra_data (b0a),
      .rb_en   (d_rd),
      .rb_addr (d_row),
      .rb_data (b0b),
      .we      (we0),
      .waddr   (d_row),
      .wdata   (data_sram_wdata)
   );

   sram_bank_2r1w #(.ROW_W(ROW_W)) u_bank1 (
      .clk     (clk),
      .ra_en   (i_req),
      .ra_addr (i_row),
      .ra_data (b1a),
      .rb_en   (d_rd),
      .rb_addr (d_row),
      .rb_data (b1b),
      .we      (we1),
      .waddr   (d_row),
      .wdata   (data_sram_wdata)
   );

   // Response tags, sticky errors and collision counter next state
   always_comb begin
      i_vld_d = i_vld_q;
      i_odd_d = i_odd_q;
      i_oor_d = i_oor_q;
      d_vld_d = d_vld_q;
      d_odd_d = d_odd_q;
      d_oor_d = d_oor_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      if (i_req) begin
         i_vld_d = 1'b1;
         i_odd_d = i_odd;
         i_oor_d = i_oor;
      end
      if (d_rd) begin
         d_vld_d = 1'b1;
         d_odd_d = d_odd;
         d_oor_d = d_oor;
      end
      if ((i_req & i_oor) | (d_req & d_oor))
         err_d[0] = 1'b1;
      if (i_req & (|inst_sram_wen))
         err_d[1] = 1'b1;
      if (coll && cnt_q != 16'hFFFF)
         cnt_d = cnt_q + 16'd1;
   end

   // State registers; reset discards any in-flight read
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         i_vld_q <= 1'b0;
         i_odd_q <= 1'b0;
         i_oor_q <= 1'b0;
         d_vld_q <= 1'b0;
         d_odd_q <= 1'b0;
         d_oor_q <= 1'b0;
         err_q   <= 2'b00;
         cnt_q   <= 16'h0;
      end else begin
         i_vld_q <= i_vld_d;
         i_odd_q <= i_odd_d;
         i_oor_q <= i_oor_d;
         d_vld_q <= d_vld_d;
         d_odd_q <= d_odd_d;
         d_oor_q <= d_oor_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   // Swap bank halves into address order
   always_comb begin
      inst_sram_rdata = 64'h0;
      data_sram_rdata = 32'h0;
      if (i_vld_q) begin
         if (i_oor_q)
            inst_sram_rdata = {OOR_DATA, OOR_DATA};
         else if (i_odd_q)
            inst_sram_rdata = {b0a, b1a};
         else
            inst_sram_rdata = {b1a, b0a};
      end
      if (d_vld_q) begin
         if (d_oor_q)
            data_sram_rdata = OOR_DATA;
         else
            data_sram_rdata = d_odd_q ? b1b : b0b;
      end
   end

   assign err_o          = err_q;
   assign conflict_cnt_o = cnt_q;

endmodule
